// File: rtl/miner_array_ctrl_if.sv
// miner_array_ctrl_if: 8-bit memory-mapped slave bus for the miner array controller.
//   write      - write strobe, qualified by chipselect
//   read       - read strobe, qualified by chipselect
//   chipselect - selects this block
//   address    - byte address (0..127)
//   writedata  - write byte
//   readdata   - registered read byte, valid one cycle after a qualified read
interface miner_array_ctrl_if;
  logic       write;
  logic       read;
  logic       chipselect;
  logic [6:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (
    output write, read, chipselect, address, writedata,
    input  readdata
  );

  modport slave (
    input  write, read, chipselect, address, writedata,
    output readdata
  );
endinterface

// File: rtl/miner_array_ctrl.sv
// miner_array_ctrl: host-facing controller for NUM_MINERS SHA-256d cores.
// Loads a 96-byte header over the byte bus, splits the nonce space into
// per-core ranges, launches all cores with one pulse, then picks the
// lowest-index golden hit or reports exhaustion after a timeout.
//   clk              - clock, rising edge
//   reset            - asynchronous, active-high
//   bus              - slave side of the byte bus (see miner_array_ctrl_if)
//   miner_header     - header shared by all cores
//   miner_nonce_base - start nonce per core, core i in bits [32i+31:32i]
//   miner_load       - one-cycle launch pulse
//   miner_found      - per-core golden-hit strobe
//   miner_nonce      - per-core nonce, valid with the matching found bit
module miner_array_ctrl #(
  parameter int unsigned NUM_MINERS  = 2,
  parameter logic [31:0] NONCE_RANGE = 32'd100000,
  parameter logic [7:0]  PIPE_LAT    = 8'd134
) (
  input  logic                      clk,
  input  logic                      reset,
  miner_array_ctrl_if.slave         bus,
  output logic [767:0]              miner_header,
  output logic [32*NUM_MINERS-1:0]  miner_nonce_base,
  output logic                      miner_load,
  input  logic [NUM_MINERS-1:0]     miner_found,
  input  logic [32*NUM_MINERS-1:0]  miner_nonce
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLoad      = 3'd1,
    StRun       = 3'd2,
    StFound     = 3'd3,
    StExhausted = 3'd4
  } state_e;

  localparam logic [31:0] Timeout = NONCE_RANGE + {24'd0, PIPE_LAT} - 32'd1;

  state_e      state;
  logic        launch_pend;  // byte 95 written; RUN entry and load pulse follow
  logic [31:0] cnt;
  logic [31:0] golden;
  logic [3:0]  winner;
  logic        found;
  logic        exhausted;

  // Bus decode
  logic wr_en, rd_en, hdr_wr, ctl_wr, start, abort;
  assign wr_en  = bus.chipselect & bus.write;
  assign rd_en  = bus.chipselect & bus.read;
  assign hdr_wr = wr_en && (bus.address < 7'd96);
  assign ctl_wr = wr_en && (bus.address == 7'd101);
  assign start  = ctl_wr & bus.writedata[0];
  assign abort  = ctl_wr & bus.writedata[1];

  // Lowest set found bit wins
  logic        hit;
  logic [3:0]  hit_idx;
  logic [31:0] hit_nonce;
  always_comb begin
    hit       = |miner_found;
    hit_idx   = '0;
    hit_nonce = '0;
    for (int i = int'(NUM_MINERS) - 1; i >= 0; i--) begin
      if (miner_found[i]) begin
        hit_idx   = 4'(i);
        hit_nonce = miner_nonce[32*i +: 32];
      end
    end
  end

  // Per-core start nonces; wrap mod 2^32 is intended
  logic [31:0]             nonce_field;
  logic [32*NUM_MINERS-1:0] base_next;
  assign nonce_field = miner_header[383:352];
  always_comb begin
    base_next = '0;
    for (int i = 0; i < int'(NUM_MINERS); i++) begin
      base_next[32*i +: 32] = nonce_field + 32'(i) * NONCE_RANGE;
    end
  end

  // Read mux sees pre-write state, so a read returns the value held before
  // any same-cycle write.
  logic [7:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (bus.address < 7'd96) begin
      rd_val = miner_header[{bus.address, 3'b000} +: 8];
    end else begin
      case (bus.address)
        7'd96:   rd_val = golden[7:0];
        7'd97:   rd_val = golden[15:8];
        7'd98:   rd_val = golden[23:16];
        7'd99:   rd_val = golden[31:24];
        7'd100:  rd_val = {3'b000, state, exhausted, found};
        7'd102:  rd_val = {4'b0000, winner};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= StIdle;
      launch_pend      <= 1'b0;
      cnt              <= '0;
      golden           <= '0;
      winner           <= '0;
      found            <= 1'b0;
      exhausted        <= 1'b0;
      miner_header     <= '0;
      miner_nonce_base <= '0;
      miner_load       <= 1'b0;
      bus.readdata     <= '0;
    end else begin
      miner_load <= 1'b0;
      if (rd_en) begin
        bus.readdata <= rd_val;
      end

      // Control writes take precedence over any same-cycle hit or timeout.
      // Start always (re)enters LOAD with cleared results; abort is
      // meaningless in IDLE and loses to start there.
      if (start && !(abort && state != StIdle)) begin
        state        <= StLoad;
        launch_pend  <= 1'b0;
        miner_header <= '0;
        golden       <= '0;
        winner       <= '0;
        found        <= 1'b0;
        exhausted    <= 1'b0;
      end else if (abort && state != StIdle) begin
        state       <= StIdle;
        launch_pend <= 1'b0;
      end else begin
        case (state)
          StIdle: ;
          StLoad: begin
            if (launch_pend) begin
              state            <= StRun;
              launch_pend      <= 1'b0;
              miner_load       <= 1'b1;
              miner_nonce_base <= base_next;
              cnt              <= '0;
            end else if (hdr_wr) begin
              miner_header[{bus.address, 3'b000} +: 8] <= bus.writedata;
              if (bus.address == 7'd95) begin
                launch_pend <= 1'b1;
              end
            end
          end
          StRun: begin
            // Found beats timeout expiry in the same cycle
            if (hit) begin
              state  <= StFound;
              golden <= hit_nonce;
              winner <= hit_idx;
              found  <= 1'b1;
            end else if (cnt == Timeout) begin
              state     <= StExhausted;
              exhausted <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          StFound, StExhausted: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
